// File: rtl/srt4_post_processing.sv
// SRT radix-4 divider final stage: remainder sign fix, quotient conversion, de-normalisation.
// Optional SRT4_POST_SIGNED_EN adds a SIGN state applying result negation.
module srt4_post_processing #(
    parameter int DW = 32,
    parameter int RW = DW + 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW+1:0]   q_pos,
    input  logic [DW+1:0]   q_neg,
    input  logic [RW-1:0]   rem_in,
    input  logic [DW+2:0]   divisor_star,
    input  logic [DW/2-1:0] recovery,
    input  logic [DW-1:0]   dividend,
`ifdef SRT4_POST_SIGNED_EN
    input  logic            quot_neg,
    input  logic            rem_neg,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            busy
);
    localparam int SW = DW/2 + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CORRECT = 3'd1,
        NORM    = 3'd2,
`ifdef SRT4_POST_SIGNED_EN
        SIGN    = 3'd3,
`endif
        DONE    = 3'd4
    } state_t;

    state_t state, next_state;

    logic [DW+1:0]   q_pos_r, q_neg_r, q_c;
    logic [RW-1:0]   rem_r, r_c;
    logic [DW+2:0]   div_r;
    logic [DW/2-1:0] rec_r;
    logic [DW-1:0]   dvd_r;
`ifdef SRT4_POST_SIGNED_EN
    logic            qn_r, rn_r;
    logic [DW-1:0]   quot_n, rem_n;
`endif

    logic [DW+1:0] q_raw;
    logic [RW-1:0] div_ext, r_sh;
    logic [SW-1:0] shamt;
    logic          rec_zero;
    logic          unused_bits;

    assign q_raw    = q_pos_r - q_neg_r;
    assign div_ext  = {{(RW-DW-3){1'b0}}, div_r};
    // remainder is scaled by 2^(DW+1-recovery); undo that here
    assign shamt    = SW'(DW + 1) - {1'b0, rec_r};
    assign r_sh     = r_c >> shamt;
    assign rec_zero = (rec_r == '0);
    assign unused_bits = ^{q_c[DW+1:DW], r_sh[RW-1:DW]};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = CORRECT;
            CORRECT: next_state = NORM;
`ifdef SRT4_POST_SIGNED_EN
            NORM:    next_state = SIGN;
            SIGN:    next_state = DONE;
`else
            NORM:    next_state = DONE;
`endif
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_pos_r   <= '0;
            q_neg_r   <= '0;
            rem_r     <= '0;
            div_r     <= '0;
            rec_r     <= '0;
            dvd_r     <= '0;
            r_c       <= '0;
            q_c       <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef SRT4_POST_SIGNED_EN
            qn_r      <= 1'b0;
            rn_r      <= 1'b0;
            quot_n    <= '0;
            rem_n     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    q_pos_r <= q_pos;
                    q_neg_r <= q_neg;
                    rem_r   <= rem_in;
                    div_r   <= divisor_star;
                    rec_r   <= recovery;
                    dvd_r   <= dividend;
`ifdef SRT4_POST_SIGNED_EN
                    qn_r    <= quot_neg;
                    rn_r    <= rem_neg;
`endif
                end
                CORRECT: begin
                    // negative remainder overshot by one divisor: add it back, drop one quotient unit
                    if (rem_r[RW-1]) begin
                        r_c <= rem_r + div_ext;
                        q_c <= q_raw - 1'b1;
                    end else begin
                        r_c <= rem_r;
                        q_c <= q_raw;
                    end
                end
`ifdef SRT4_POST_SIGNED_EN
                NORM: begin
                    quot_n <= rec_zero ? '1    : q_c[DW-1:0];
                    rem_n  <= rec_zero ? dvd_r : r_sh[DW-1:0];
                end
                SIGN: begin
                    if (rec_zero) begin
                        quotient  <= quot_n;
                        remainder <= rem_n;
                    end else begin
                        quotient  <= qn_r ? (~quot_n + 1'b1) : quot_n;
                        remainder <= rn_r ? (~rem_n + 1'b1)  : rem_n;
                    end
                end
`else
                NORM: begin
                    quotient  <= rec_zero ? '1    : q_c[DW-1:0];
                    remainder <= rec_zero ? dvd_r : r_sh[DW-1:0];
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_srt4_post_processing.sv
// Directed bench for srt4_post_processing; build with SRT4_POST_SIGNED_EN for the signed path.
module tb_srt4_post_processing;
    localparam int DW = 32;
    localparam int RW = DW + 6;
`ifdef SRT4_POST_SIGNED_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW+1:0]   q_pos, q_neg;
    logic [RW-1:0]   rem_in;
    logic [DW+2:0]   divisor_star;
    logic [DW/2-1:0] recovery;
    logic [DW-1:0]   dividend;
`ifdef SRT4_POST_SIGNED_EN
    logic            quot_neg, rem_neg;
`endif
    logic            out_valid, out_ready, busy;
    logic [DW-1:0]   quotient, remainder;

    int errors = 0;
    int checks = 0;

    srt4_post_processing #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .q_pos(q_pos), .q_neg(q_neg), .rem_in(rem_in),
        .divisor_star(divisor_star), .recovery(recovery), .dividend(dividend),
`ifdef SRT4_POST_SIGNED_EN
        .quot_neg(quot_neg), .rem_neg(rem_neg),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic [DW+1:0] qp, input logic [DW+1:0] qn,
                          input logic [RW-1:0] rin, input logic [DW+2:0] ds,
                          input logic [DW/2-1:0] rec, input logic [DW-1:0] dvd);
        q_pos = qp; q_neg = qn; rem_in = rin;
        divisor_star = ds; recovery = rec; dividend = dvd;
    endtask

    // 100/7: q_pos-q_neg = 14, rem 2<<30 with recovery 3 (shift 30)
    task automatic vec_100_7();
        set_in(34'd20, 34'd6, 38'h00_8000_0000, 35'h0_E000_0000, 16'd3, 32'd100);
    endtask

    // 0xFFFFFFFF/0x10: negative remainder, q_raw 0x10000000, shift 28
    task automatic vec_neg_rem();
        set_in(34'h1555_5555, 34'h0555_5555, 38'h3F_F000_0000, 35'h1_0000_0000, 16'd5, 32'hFFFF_FFFF);
    endtask

    task automatic vec_div0();
        set_in(34'd0, 34'd0, 38'd0, 35'd0, 16'd0, 32'h0000_1234);
    endtask

    // Presents the current inputs, counts edges from the accept edge to out_valid; -1 on timeout.
    task automatic run_div(output int lat);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient: got %h want 0", quotient); end
        rst = 1'b0;
        // load a nonzero result, then abandon a division in CORRECT
        vec_100_7();
        run_div(lat);
        @(posedge clk); #1;
        vec_neg_rem();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL midreset_quotient: got %h want 0", quotient); end
        checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL midreset_remainder: got %h want 0", remainder); end
        lat = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) lat++;
        end
        checks++; if (lat !== 0) begin errors++; $display("FAIL midreset_stale: got %0d valid cycles want 0", lat); end
    endtask

    task automatic test_positive();
        int lat;
        vec_100_7();
        run_div(lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL pos_latency: got %0d want %0d", lat, LAT); end
        checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL pos_quotient: got %h want 0000000e", quotient); end
        checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL pos_remainder: got %h want 00000002", remainder); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pos_valid_drop: got %b want 0", out_valid); end
        checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL pos_hold: got %h want 0000000e", quotient); end
    endtask

    task automatic test_correction();
        int lat;
        vec_neg_rem();
        run_div(lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL corr_latency: got %0d want %0d", lat, LAT); end
        checks++; if (quotient !== 32'h0FFF_FFFF) begin errors++; $display("FAIL corr_quotient: got %h want 0fffffff", quotient); end
        checks++; if (remainder !== 32'h0000_000F) begin errors++; $display("FAIL corr_remainder: got %h want 0000000f", remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        int lat;
        vec_div0();
        run_div(lat);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL dz_latency: got %0d want %0d", lat, LAT); end
        checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_quotient: got %h want ffffffff", quotient); end
        checks++; if (remainder !== 32'h0000_1234) begin errors++; $display("FAIL dz_remainder: got %h want 00001234", remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        out_ready = 1'b0;
        vec_100_7();
        in_valid = 1'b1;
        @(posedge clk); #1;
        vec_div0();
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT); end
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d bad cycles want 0 (q=%h r=%h)", bad, quotient, remainder); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_handshake: got valid,ready=%b want 01", {out_valid, in_ready}); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_second_accept: got busy=%b want 1", busy); end
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL bp2_latency: got %0d want %0d", lat, LAT); end
        checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bp2_quotient: got %h want ffffffff", quotient); end
        checks++; if (remainder !== 32'h0000_1234) begin errors++; $display("FAIL bp2_remainder: got %h want 00001234", remainder); end
        @(posedge clk); #1;
    endtask

`ifdef SRT4_POST_SIGNED_EN
    task automatic test_signed();
        int lat;
        quot_neg = 1'b1; rem_neg = 1'b1;
        vec_100_7();
        run_div(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL sgn_latency: got %0d want 4", lat); end
        checks++; if (quotient !== 32'hFFFF_FFF2) begin errors++; $display("FAIL sgn_quotient: got %h want fffffff2", quotient); end
        checks++; if (remainder !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sgn_remainder: got %h want fffffffe", remainder); end
        @(posedge clk); #1;
        vec_div0();
        run_div(lat);
        checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sgn_dz_quotient: got %h want ffffffff", quotient); end
        checks++; if (remainder !== 32'h0000_1234) begin errors++; $display("FAIL sgn_dz_remainder: got %h want 00001234", remainder); end
        @(posedge clk); #1;
        quot_neg = 1'b0; rem_neg = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
`ifdef SRT4_POST_SIGNED_EN
        quot_neg = 1'b0; rem_neg = 1'b0;
`endif
        vec_div0();
        test_reset();
        test_positive();
        test_correction();
        test_div_zero();
        test_back_to_back();
`ifdef SRT4_POST_SIGNED_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
